// File: rtl/mem_stream_loader_pkg.sv
// Shared types and constants for the framed program-memory loader.
// Frame: SYNC, addr_lo, addr_hi, cnt_lo, cnt_hi, 4*cnt data bytes, chk.
package mem_stream_loader_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  localparam logic [1:0] ADDR_LO = 2'd0;
  localparam logic [1:0] ADDR_HI = 2'd1;
  localparam logic [1:0] CNT_LO  = 2'd2;
  localparam logic [1:0] CNT_HI  = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    DATA,
    WR,
    CHK
  } state_t;

endpackage

// File: rtl/mem_loader_timeout.sv
// Inter-byte idle watchdog: reloads on clear, counts down while enabled.
// expire is high once LIMIT enabled cycles have passed since the last clear.
module mem_loader_timeout #(
  parameter int unsigned LIMIT = 1000000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= CW'(LIMIT);
    end else if (clear) begin
      cnt_q <= CW'(LIMIT);
    end else if (enable && cnt_q != '0) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  assign expire = (cnt_q == '0);

endmodule

// File: rtl/mem_stream_loader.sv
// Framed byte-stream loader writing little-endian words into program memory.
// Holds the CPU in reset while a frame is in flight.
module mem_stream_loader
  import mem_stream_loader_pkg::*;
#(
  parameter int          ADDR_W         = mem_stream_loader_pkg::ADDR_W,
  parameter logic [7:0]  SYNC_BYTE      = mem_stream_loader_pkg::SYNC_BYTE,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_address,
  output logic [3:0]        mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error
);

  state_t state_q, state_d;

  logic [1:0]        hdr_idx_q;
  logic [1:0]        byte_idx_q;
  logic [7:0]        hdr_lo_q;
  logic [ADDR_W-1:0] addr_ptr_q;
  logic [15:0]       words_left_q;
  logic [DATA_W-1:0] shift_q;
  logic [7:0]        chk_q;
  logic              done_q;
  logic              error_q;
  logic              rdy_en_q;

  logic acc;
  logic in_frame;
  logic expire;
  logic timed_out;

  assign acc       = in_valid & in_ready;
  assign in_frame  = (state_q == HDR) || (state_q == DATA) ||
                     (state_q == CHK);
  assign timed_out = expire & in_frame;

  mem_loader_timeout #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (acc | ~in_frame),
    .enable  (in_frame),
    .expire  (expire)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (acc && in_data == SYNC_BYTE) state_d = HDR;
      end
      HDR: begin
        if (timed_out) begin
          state_d = IDLE;
        end else if (acc && hdr_idx_q == CNT_HI) begin
          state_d = ({in_data, hdr_lo_q} == 16'd0) ? CHK : DATA;
        end
      end
      DATA: begin
        if (timed_out) begin
          state_d = IDLE;
        end else if (acc && byte_idx_q == 2'd3) begin
          state_d = WR;
        end
      end
      WR: begin
        state_d = (words_left_q == 16'd1) ? CHK : DATA;
      end
      CHK: begin
        if (timed_out || acc) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready       = 1'b0;
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    unique case (state_q)
      IDLE:          in_ready = rdy_en_q;
      HDR, DATA, CHK: in_ready = ~timed_out;
      WR: begin
        mem_chipselect = 1'b1;
        mem_write      = 1'b1;
      end
      default: in_ready = 1'b0;
    endcase
  end

  // Stream is refused for the first cycle out of reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdy_en_q     <= 1'b0;
      hdr_idx_q    <= '0;
      byte_idx_q   <= '0;
      hdr_lo_q     <= '0;
      addr_ptr_q   <= '0;
      words_left_q <= '0;
      shift_q      <= '0;
      chk_q        <= '0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      rdy_en_q <= 1'b1;
      done_q   <= 1'b0;
      error_q  <= timed_out;
      if (acc) begin
        unique case (state_q)
          IDLE: begin
            chk_q      <= '0;
            hdr_idx_q  <= '0;
            byte_idx_q <= '0;
          end
          HDR: begin
            chk_q     <= chk_q ^ in_data;
            hdr_idx_q <= hdr_idx_q + 2'd1;
            hdr_lo_q  <= in_data;
            if (hdr_idx_q == ADDR_HI)
              addr_ptr_q <= ADDR_W'({in_data, hdr_lo_q});
            if (hdr_idx_q == CNT_HI)
              words_left_q <= {in_data, hdr_lo_q};
          end
          DATA: begin
            chk_q <= chk_q ^ in_data;
            shift_q[{byte_idx_q, 3'b000} +: 8] <= in_data;
            byte_idx_q <= byte_idx_q + 2'd1;
          end
          CHK: begin
            done_q  <= (in_data == chk_q);
            error_q <= (in_data != chk_q);
          end
          default: ;
        endcase
      end
      if (state_q == WR) begin
        addr_ptr_q   <= addr_ptr_q + ADDR_W'(1);
        words_left_q <= words_left_q - 16'd1;
      end
    end
  end

  assign mem_address    = addr_ptr_q;
  assign mem_writedata  = shift_q;
  assign mem_byteenable = 4'hF;
  assign mem_clken      = 1'b1;
  assign busy           = (state_q != IDLE);
  assign cpu_hold       = busy;
  assign done           = done_q;
  assign error          = error_q;

endmodule

// File: tb/tb_mem_stream_loader.sv
// Scoreboard bench for mem_stream_loader: expected writes/pulses queued
// at stimulus time, popped by a negedge monitor.
module tb_mem_stream_loader;
  import mem_stream_loader_pkg::*;

  localparam int TMO = 16;
  localparam int K_WR   = 0;
  localparam int K_DONE = 1;
  localparam int K_ERR  = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect;
  logic        mem_write;
  logic [31:0] mem_writedata;
  logic        mem_clken;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        error;

  mem_stream_loader #(
    .ADDR_W         (16),
    .SYNC_BYTE      (8'hA5),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .mem_address    (mem_address),
    .mem_byteenable (mem_byteenable),
    .mem_chipselect (mem_chipselect),
    .mem_write      (mem_write),
    .mem_writedata  (mem_writedata),
    .mem_clken      (mem_clken),
    .cpu_hold       (cpu_hold),
    .busy           (busy),
    .done           (done),
    .error          (error)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    logic [15:0] addr;
    logic [31:0] data;
  } ev_t;

  typedef logic [7:0] bq_t[$];

  ev_t exp_q[$];
  int  total = 0;
  int  bad = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic expect_ev(int kind, logic [15:0] a, logic [31:0] d);
    ev_t e;
    e.kind = kind;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic send(logic [7:0] b);
    int n;
    n = 0;
    in_data  = b;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("send_ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_all(bq_t q);
    foreach (q[i]) send(q[i]);
  endtask

  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_frame1(int kind);
    expect_ev(K_WR, 16'h0010, 32'h12345678);
    expect_ev(K_WR, 16'h0011, 32'hDEADBEEF);
    expect_ev(kind, 16'h0, 32'h0);
  endtask

  // Monitor: every write and every pulse must match the queue head.
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (mem_write || mem_chipselect) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", {16'h0, mem_address}, 32'hFFFFFFFF);
        end else begin
          e = exp_q.pop_front();
          check("wr_kind", e.kind, K_WR);
          check("wr_addr", {16'h0, mem_address}, {16'h0, e.addr});
          check("wr_data", mem_writedata, e.data);
          check("wr_be", {28'h0, mem_byteenable}, 32'hF);
          check("wr_cs_pair", {31'h0, mem_chipselect & mem_write}, 32'd1);
          check("wr_hold", {31'h0, cpu_hold}, 32'd1);
        end
      end
      if (done || error) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", {30'h0, done, error}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("pulse_kind", done ? K_DONE : K_ERR, e.kind);
          check("pulse_both", {31'h0, done & error}, 32'd0);
          check("pulse_hold", {31'h0, cpu_hold}, 32'd0);
          check("pulse_busy", {31'h0, busy}, 32'd0);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t f1, f1_bad, f_wrap, f_empty, f_tmo, f_rst;
    f1      = '{SYNC_BYTE, 8'h10, 8'h00, 8'h02, 8'h00, 8'h78, 8'h56,
                8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h38};
    f1_bad  = '{8'hA5, 8'h10, 8'h00, 8'h02, 8'h00, 8'h78, 8'h56,
                8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h39};
    f_wrap  = '{8'hA5, 8'hFF, 8'hFF, 8'h02, 8'h00, 8'h44, 8'h33,
                8'h22, 8'h11, 8'h88, 8'h77, 8'h66, 8'h55, 8'h8A};
    f_empty = '{8'h00, 8'h00, 8'h00, 8'h00};
    f_tmo   = '{8'hA5, 8'h20, 8'h00, 8'h01, 8'h00, 8'hAA, 8'hBB};
    f_rst   = '{8'hA5, 8'h30, 8'h00, 8'h01, 8'h00, 8'h11, 8'h22};

    #12;
    check("rst_in_ready", {31'h0, in_ready}, 32'd0);
    check("rst_cs", {31'h0, mem_chipselect}, 32'd0);
    check("rst_write", {31'h0, mem_write}, 32'd0);
    check("rst_addr", {16'h0, mem_address}, 32'd0);
    check("rst_wdata", mem_writedata, 32'd0);
    check("rst_be", {28'h0, mem_byteenable}, 32'hF);
    check("rst_clken", {31'h0, mem_clken}, 32'd1);
    check("rst_flags", {28'h0, cpu_hold, busy, done, error}, 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    idle(2);

    expect_frame1(K_DONE);
    send_all(f1);
    idle(3);

    expect_frame1(K_ERR);
    send_all(f1_bad);
    idle(3);

    expect_ev(K_WR, 16'hFFFF, 32'h11223344);
    expect_ev(K_WR, 16'h0000, 32'h55667788);
    expect_ev(K_DONE, 16'h0, 32'h0);
    send_all(f_wrap);
    idle(3);

    check("empty_hold_pre", {31'h0, cpu_hold}, 32'd0);
    send(8'hA5);
    check("empty_hold_sync", {30'h0, cpu_hold, busy}, 32'd3);
    send_all(f_empty);
    check("empty_hold_hdr", {31'h0, cpu_hold}, 32'd1);
    expect_ev(K_DONE, 16'h0, 32'h0);
    send(8'h00);
    check("empty_hold_end", {31'h0, cpu_hold}, 32'd0);
    idle(3);

    send(8'h00);
    send(8'h5A);
    send(8'hFF);
    check("garbage_hold", {30'h0, cpu_hold, busy}, 32'd0);
    expect_frame1(K_DONE);
    send_all(f1);
    idle(3);

    expect_ev(K_ERR, 16'h0, 32'h0);
    send_all(f_tmo);
    idle(TMO - 1);
    check("tmo_still_busy", {31'h0, busy}, 32'd1);
    idle(5);
    check("tmo_idle", {30'h0, cpu_hold, busy}, 32'd0);
    expect_frame1(K_DONE);
    send_all(f1);
    idle(3);

    send_all(f_rst);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_flags", {28'h0, cpu_hold, busy, done, error}, 32'd0);
    check("mid_rst_io", {29'h0, in_ready, mem_chipselect, mem_write},
          32'd0);
    check("mid_rst_wdata", mem_writedata, 32'd0);
    check("mid_rst_be", {27'h0, mem_clken, mem_byteenable}, 32'h1F);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    idle(3);
    expect_frame1(K_DONE);
    send_all(f1);
    idle(5);

    check("queue_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_stream_loader.md
Name: mem_stream_loader

Overview:
- Upstream loader for the 32-bit × 64K-word on-chip program memory.
- Accepts a framed byte stream (valid/ready) from the host UART bridge and assembles little-endian 32-bit words.
- Writes those words into the memory's Avalon-MM slave port, one single-cycle write per word.
- Holds the CPU in reset while a frame is loading, and reports completion or error.

Parameters:
- ADDR_W, 16, memory word-address width; addresses wrap modulo 2^ADDR_W.
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CYCLES, 1000000, maximum idle cycles between bytes inside a frame before abort; must be ≥ 2.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- in_data  in  8  stream byte.
- in_valid  in  1  byte valid.
- in_ready  out  1  loader can accept a byte.
- mem_address  out  ADDR_W  memory word address.
- mem_byteenable  out  4  always 4'hF during a write.
- mem_chipselect  out  1  memory select.
- mem_write  out  1  write strobe.
- mem_writedata  out  32  assembled word.
- mem_clken  out  1  memory clock enable; constant 1.
- cpu_hold  out  1  CPU reset request while loading.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse: frame completed with good checksum.
- error  out  1  one-cycle pulse: bad checksum or timeout.

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous assert, synchronous deassert, active-low.
- Reset values: every output is 0 except mem_clken=1 and mem_byteenable=4'hF. State = IDLE; all counters and accumulators = 0.
- Byte acceptance: a byte is taken when in_valid & in_ready.
- Frame format: SYNC_BYTE, addr_lo, addr_hi, cnt_lo, cnt_hi, then 4*cnt data bytes (little-endian per word), then chk.
  - chk = XOR of every byte after SYNC up to and including the last data byte.
- State machine:
  - IDLE: in_ready=1. Non-sync bytes are discarded with no other effect. A SYNC byte moves to HDR, sets cpu_hold=1 and busy=1, and clears the checksum accumulator.
  - HDR: accepts 4 bytes into start address and word count. If count==0, go to CHK; otherwise go to DATA.
  - DATA: accepts bytes into a shift register, placing byte i at bits [8i+7:8i]. After the 4th byte, go to WR.
  - WR: lasts exactly one cycle with in_ready=0 and mem_chipselect=mem_write=1. mem_address = current pointer; mem_writedata = assembled word.
    - The pointer increments with wrap (0xFFFF -> 0x0000) and the remaining count decrements.
    - If remaining count becomes 0, go to CHK; otherwise return to DATA.
  - CHK: accepts 1 byte and compares it with the accumulator.
    - Match: done=1 for one cycle.
    - Mismatch: error=1 for one cycle.
    - Either way, return to IDLE. cpu_hold and busy drop in the same cycle as the done/error pulse.
- Write latency: the memory write occurs the cycle after the 4th data byte is accepted. The memory has no waitrequest, so every write completes in one cycle.
- mem_chipselect and mem_write are asserted only in WR; no reads are ever issued.
- No rollback: words already written by a frame that later fails its checksum remain in memory.
- Timeout: in HDR, DATA or CHK, a counter increments on every cycle without an accepted byte and clears on each accepted byte.
  - When the counter reaches TIMEOUT_CYCLES: error pulse, partial word discarded (no write), return to IDLE, cpu_hold and busy cleared.
  - The counter is held at 0 in IDLE and WR.
- SYNC_BYTE received inside a frame is treated as ordinary data; resynchronisation happens only via timeout or reset.
- reset_n asserted mid-frame: immediate return to reset values, including cpu_hold=0. No partial write is issued.
- Word count is 16 bits; the maximum of 65535 words per frame is allowed. Address wrap within a frame is legal.

Decomposition:
- Shared package holds:
  - state enum {IDLE, HDR, DATA, WR, CHK};
  - SYNC_BYTE default;
  - header byte-index constants (ADDR_LO=0 … CNT_HI=3);
  - width constants ADDR_W=16 and DATA_W=32.
- One natural sub-module, mem_loader_timeout: a loadable down-counter with clear and expire outputs.
- The FSM, word assembler and checksum stay in the top module.

Test Plan:
- Good frame: A5 10 00 02 00 78 56 34 12 EF BE AD DE 38 -> writes 0x12345678 @0x0010 and 0xDEADBEEF @0x0011, each a single-cycle write with byteenable F. Then done pulse, error=0, cpu_hold falls with done.
- Same frame with chk=39 -> both writes still occur; error pulse; done=0.
- Wrap: addr FFFF, cnt 2 -> writes at 0xFFFF then 0x0000, and the frame completes with done when chk is correct.
- Empty frame: A5 00 00 00 00 00 -> no mem_write; done pulse; cpu_hold high for exactly the frame duration.
- Garbage 00 5A FF then a good frame -> garbage ignored, cpu_hold stays 0 until A5, then the frame loads normally.
- TIMEOUT_CYCLES=16: stall 16 cycles after 2 data bytes -> error pulse, no write, IDLE. A subsequent good frame loads correctly.
- reset_n pulsed low mid-DATA -> all outputs return to reset values asynchronously, with no spurious write.
